dfr_input_mask: RTL and testbench

// - Input masking stage directly upstream of the reservoir, i.e. the stage that drives its din.
// - Accepts one scalar input sample per handshake.
// - Time-multiplexes the sample over VIRTUAL_NODES consecutive clocks, multiplying it by a
//   per-node mask value held in a writable mask register file.
// - Emits one masked value per clock, aligned to the reservoir delay-line shift.
// - The reservoir has no stall: m_data is driven every cycle and is zero when idle.

---
 rtl/dfr_input_mask.sv | 137 +++++++++++++
 tb/tb_dfr_input_mask.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dfr_input_mask.sv
// Input masking stage ahead of the reservoir: each accepted sample is replayed for
// VIRTUAL_NODES clocks, scaled by a per-node Q1.(MASK_WIDTH-1) mask and saturated.
module dfr_input_mask #(
  parameter int unsigned VIRTUAL_NODES = 10,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned MASK_WIDTH    = 16,
  parameter int unsigned ADDR_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mask_we,
  input  logic [ADDR_WIDTH-1:0] mask_addr,
  input  logic [MASK_WIDTH-1:0] mask_wdata,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_node,
  output logic                  m_last
);

  localparam int unsigned PROD_WIDTH = DATA_WIDTH + MASK_WIDTH;
  localparam int unsigned HI_WIDTH   = PROD_WIDTH - DATA_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_NODE = ADDR_WIDTH'(VIRTUAL_NODES - 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   sample_q, sample_d;
  logic [MASK_WIDTH-1:0]   mask_q [VIRTUAL_NODES];
  logic [MASK_WIDTH-1:0]   mask_d [VIRTUAL_NODES];
  logic                    m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
  logic [ADDR_WIDTH-1:0]   m_node_q, m_node_d;
  logic                    m_last_q, m_last_d;

  logic [MASK_WIDTH-1:0]   mask_rd;
  logic signed [PROD_WIDTH-1:0] prod, prod_sh;
  logic [HI_WIDTH-1:0]     prod_hi;
  logic [DATA_WIDTH-1:0]   sat_val;

  assign s_ready = (state_q == IDLE) || (cnt_q == LAST_NODE);

  // Mask entry for the node being emitted; reads the pre-write value.
  always_comb begin
    mask_rd = '0;
    for (int unsigned i = 0; i < VIRTUAL_NODES; i++) begin
      if (cnt_q == ADDR_WIDTH'(i)) mask_rd = mask_q[i];
    end
  end

  // Signed product, floor-shift back to data scale, clamp to DATA_WIDTH.
  always_comb begin
    prod    = PROD_WIDTH'($signed(sample_q)) * PROD_WIDTH'($signed(mask_rd));
    prod_sh = prod >>> (MASK_WIDTH - 1);
    prod_hi = prod_sh[PROD_WIDTH-1:DATA_WIDTH-1];
    if (prod_hi == '0 || prod_hi == '1) begin
      sat_val = prod_sh[DATA_WIDTH-1:0];
    end else if (prod_sh[PROD_WIDTH-1]) begin
      sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sample_d  = sample_q;
    m_valid_d = 1'b0;
    m_data_d  = '0;
    m_node_d  = '0;
    m_last_d  = 1'b0;
    mask_d    = mask_q;

    for (int unsigned i = 0; i < VIRTUAL_NODES; i++) begin
      if (mask_we && (mask_addr == ADDR_WIDTH'(i))) mask_d[i] = mask_wdata;
    end

    case (state_q)
      IDLE: begin
        if (s_valid) begin
          sample_d = s_data;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        m_valid_d = 1'b1;
        m_data_d  = sat_val;
        m_node_d  = cnt_q;
        m_last_d  = (cnt_q == LAST_NODE);
        if (cnt_q != LAST_NODE) begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end else if (s_valid) begin
          // Back-to-back sample: restart without a bubble.
          sample_d = s_data;
          cnt_d    = '0;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sample_q  <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_node_q  <= '0;
      m_last_q  <= 1'b0;
      for (int unsigned i = 0; i < VIRTUAL_NODES; i++) mask_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sample_q  <= sample_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_node_q  <= m_node_d;
      m_last_q  <= m_last_d;
      mask_q    <= mask_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_node  = m_node_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_dfr_input_mask.sv
// Bench for dfr_input_mask: constant vector table, directed corner sequences and a
// randomized run against a queue-based output-stream model.
module tb_dfr_input_mask;

  localparam int VN = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        mask_we;
  logic [3:0]  mask_addr;
  logic [15:0] mask_wdata;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic [31:0] m_data;
  logic [3:0]  m_node;
  logic        m_last;

  dfr_input_mask dut (
    .clk(clk), .rst(rst),
    .mask_we(mask_we), .mask_addr(mask_addr), .mask_wdata(mask_wdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_data(m_data), .m_node(m_node), .m_last(m_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: mask contents and the stream of node outputs still owed.
  typedef struct { logic [31:0] sample; int node; } pend_t;
  pend_t       pend[$];
  logic [15:0] mask_m [VN];

  typedef struct { logic [15:0] mask; logic [31:0] sample; logic [31:0] exp; } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_mul(input logic [31:0] s, input logic [15:0] m);
    longint p;
    p = longint'($signed(s)) * longint'($signed(m));
    p = p >>> 15;
    if (p > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (p < -64'sd2147483648) return 32'h8000_0000;
    return p[31:0];
  endfunction

  // One clock: drive inputs, check ready, advance the model, check outputs.
  task automatic step(input bit v, input logic [31:0] d, input bit we,
                      input logic [3:0] a, input logic [15:0] wd, output bit acc);
    bit          exp_rdy, ev, el;
    logic [31:0] ed;
    int          en;
    pend_t       r;
    @(negedge clk);
    s_valid = v; s_data = d; mask_we = we; mask_addr = a; mask_wdata = wd;
    #1;
    exp_rdy = (pend.size() <= 1);
    check("s_ready", 64'(s_ready), 64'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk);
    ev = 0; ed = '0; en = 0; el = 0;
    if (pend.size() > 0) begin
      r  = pend.pop_front();
      ev = 1; en = r.node; el = (r.node == VN - 1);
      ed = model_mul(r.sample, mask_m[r.node]);
    end
    if (acc) for (int i = 0; i < VN; i++) pend.push_back('{d, i});
    if (we && a < VN) mask_m[a] = wd;
    #1;
    check("m_valid", 64'(m_valid), 64'(ev));
    check("m_data",  64'(m_data),  64'(ed));
    check("m_node",  64'(m_node),  64'(en));
    check("m_last",  64'(m_last),  64'(el));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0, acc);
  endtask

  task automatic fill_masks(input logic [15:0] base, input logic [15:0] inc);
    bit acc;
    for (int i = 0; i < VN; i++) step(0, '0, 1, 4'(i), 16'(base + 16'(i) * inc), acc);
  endtask

  initial begin
    vec_t        tbl[8];
    bit          acc;
    int          vcount, naccept, k;
    logic [31:0] smp[3];
    logic [31:0] cur;

    tbl[0] = '{16'h4000, 32'h0000_1000, 32'h0000_0800};
    tbl[1] = '{16'h7FFF, 32'h7FFF_FFFF, 32'h7FFE_FFFF};
    tbl[2] = '{16'h8000, 32'h8000_0000, 32'h7FFF_FFFF};
    tbl[3] = '{16'h8000, 32'h0000_0001, 32'hFFFF_FFFF};
    tbl[4] = '{16'h7FFF, 32'h8000_0000, 32'h8001_0000};
    tbl[5] = '{16'h8000, 32'h7FFF_FFFF, 32'h8000_0001};
    tbl[6] = '{16'h0800, 32'h0001_0000, 32'h0000_1000};
    tbl[7] = '{16'hC000, 32'h0000_0003, 32'hFFFF_FFFE};

    rst = 0; s_valid = 0; s_data = '0; mask_we = 0; mask_addr = '0; mask_wdata = '0;
    for (int i = 0; i < VN; i++) mask_m[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_data",  64'(m_data),  64'(0));
    check("rst_m_node",  64'(m_node),  64'(0));
    check("rst_m_last",  64'(m_last),  64'(0));
    check("rst_s_ready", 64'(s_ready), 64'(1));
    @(negedge clk); rst = 1;

    // Arithmetic table: same mask on every node, node 0 compared to a constant.
    foreach (tbl[t]) begin
      fill_masks(tbl[t].mask, 16'h0);
      step(1, tbl[t].sample, 0, '0, '0, acc);
      check("tbl_accept", 64'(acc), 64'(1));
      step(0, '0, 0, '0, '0, acc);
      check($sformatf("tbl%0d_node0", t), 64'(m_data), 64'(tbl[t].exp));
      idle(VN);
    end

    // 0.5 mask: ten outputs, last flagged only on node 9, then quiet.
    fill_masks(16'h4000, 16'h0);
    step(1, 32'h0000_1000, 0, '0, '0, acc);
    for (int i = 0; i < VN; i++) begin
      step(0, '0, 0, '0, '0, acc);
      check("t1_data", 64'(m_data), 64'h800);
      check("t1_last", 64'(m_last), 64'(i == VN - 1));
    end
    step(0, '0, 0, '0, '0, acc);
    check("t1_idle_valid", 64'(m_valid), 64'(0));

    // Ramp mask: node i yields i*0x1000, node 0 one cycle after accept.
    fill_masks(16'h0, 16'h0800);
    step(1, 32'h0001_0000, 0, '0, '0, acc);
    for (int i = 0; i < VN; i++) begin
      step(0, '0, 0, '0, '0, acc);
      check("t2_data", 64'(m_data), 64'(32'(i) * 32'h1000));
      check("t2_node", 64'(m_node), 64'(i));
    end
    idle(2);

    // Three samples with s_valid held: thirty contiguous valid cycles.
    smp[0] = 32'h0000_1111; smp[1] = 32'hFFFF_0000; smp[2] = 32'h1234_5678;
    vcount = 0; naccept = 0;
    for (int c = 0; c < 40; c++) begin
      step(naccept < 3, (naccept < 3) ? smp[naccept] : '0, 0, '0, '0, acc);
      if (acc) naccept++;
      if (m_valid) vcount++;
    end
    check("t3_accepts", 64'(naccept), 64'(3));
    check("t3_valid_cycles", 64'(vcount), 64'(30));

    // Write to mask[3] while node 3 is computed; out-of-range write ignored.
    fill_masks(16'h4000, 16'h0);
    step(1, 32'h0000_1000, 0, '0, '0, acc);
    idle(3);
    step(0, '0, 1, 4'd3, 16'h2000, acc);
    check("t5_old_mask", 64'(m_data), 64'h800);
    step(0, '0, 1, 4'd12, 16'h7FFF, acc);
    idle(VN - 4);
    step(1, 32'h0000_1000, 0, '0, '0, acc);
    for (int i = 0; i < VN; i++) begin
      step(0, '0, 0, '0, '0, acc);
      check("t5_new_mask", 64'(m_data), (i == 3) ? 64'h400 : 64'h800);
    end
    idle(1);

    // Async reset in the middle of a sample.
    fill_masks(16'h3000, 16'h0100);
    step(1, 32'h0100_0000, 0, '0, '0, acc);
    idle(6);
    check("t6_pre_node", 64'(m_node), 64'd5);
    #2 rst = 0;
    #1;
    check("t6_rst_valid", 64'(m_valid), 64'(0));
    check("t6_rst_data",  64'(m_data),  64'(0));
    check("t6_rst_node",  64'(m_node),  64'(0));
    check("t6_rst_ready", 64'(s_ready), 64'(1));
    pend.delete();
    for (int i = 0; i < VN; i++) mask_m[i] = '0;
    s_valid = 0; mask_we = 0;
    @(negedge clk); @(negedge clk); rst = 1;
    idle(3);
    step(1, 32'h0012_3456, 0, '0, '0, acc);
    step(0, '0, 0, '0, '0, acc);
    check("t6_zero_mask_valid", 64'(m_valid), 64'(1));
    check("t6_zero_mask_data",  64'(m_data),  64'(0));
    idle(VN);

    // Randomized traffic with random mask writes, including out-of-range ones.
    cur = $urandom;
    for (int c = 0; c < 800; c++) begin
      k = $urandom_range(0, 7);
      step($urandom_range(0, 3) != 0, cur, k == 0, 4'($urandom_range(0, 15)),
           16'($urandom), acc);
      if (acc) begin
        case ($urandom_range(0, 5))
          0:       cur = 32'h8000_0000;
          1:       cur = 32'h7FFF_FFFF;
          default: cur = $urandom;
        endcase
      end
    end
    idle(VN + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
